// File: rtl/regalu_pkg.sv
// Shared definitions for the regalu_pipe execution core: ALU opcodes and
// default datapath dimensions.
package regalu_pkg;

  localparam int unsigned DefaultDataW = 32;
  localparam int unsigned DefaultNregs = 32;

  // ALU opcodes (S input)
  localparam logic [2:0] OP_XOR  = 3'b000;
  localparam logic [2:0] OP_XNOR = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_NOR  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_ADD  = 3'b110;
  localparam logic [2:0] OP_SUB  = 3'b111;

  // Only ADD and SUB produce a meaningful carry.
  function automatic logic op_is_arith(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/regalu_alu.sv
// Purely combinational DATA_W-bit ALU used in the execute stage of
// regalu_pipe. Produces the result and the carry out of the top bit
// (carry is forced to 0 for the logic ops).
module regalu_alu
  import regalu_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        op_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] result_o,
  output logic              cout_o
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum;

  // Shared adder: SUB is a + ~b + Cin, so the caller chooses borrow semantics via Cin.
  always_comb begin
    b_eff    = (op_i == OP_SUB) ? ~b_i : b_i;
    sum      = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, cin_i};
    result_o = '0;
    cout_o   = op_is_arith(op_i) & sum[DATA_W];
    case (op_i)
      OP_XOR:  result_o = a_i ^ b_i;
      OP_XNOR: result_o = ~(a_i ^ b_i);
      OP_OR:   result_o = a_i | b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_AND:  result_o = a_i & b_i;
      OP_NAND: result_o = ~(a_i & b_i);
      OP_ADD:  result_o = sum[DATA_W-1:0];
      OP_SUB:  result_o = sum[DATA_W-1:0];
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/regalu_pipe.sv
// regalu_pipe: NREGS x DATA_W register file feeding a three-stage
// read / execute / writeback ALU pipeline with an immediate B operand.
// Optional macro REGALU_BYPASS_EN enables EX and WB operand forwarding;
// without it operands always come from the register file and software
// must leave two idle issue slots between dependent ops.
module regalu_pipe
  import regalu_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned NREGS  = DefaultNregs,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [AW-1:0]     asel,
  input  logic [AW-1:0]     bsel,
  input  logic [AW-1:0]     dsel,
  input  logic [2:0]        S,
  input  logic              Cin,
  input  logic              imm_sel,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] abus,
  output logic [DATA_W-1:0] bbus,
  output logic [DATA_W-1:0] dbus,
  output logic              cout,
  output logic              d_valid
);

  // Register file; entry 0 is never written so it stays at its reset value of 0.
  logic [DATA_W-1:0] rf_q [NREGS];
  logic [DATA_W-1:0] rf_d [NREGS];

  // Execute stage
  logic              ex_valid_q, ex_valid_d;
  logic [DATA_W-1:0] abus_q, abus_d;
  logic [DATA_W-1:0] bbus_q, bbus_d;
  logic [AW-1:0]     ex_dest_q, ex_dest_d;
  logic [2:0]        ex_op_q, ex_op_d;
  logic              ex_cin_q, ex_cin_d;

  // Writeback stage
  logic              d_valid_q, d_valid_d;
  logic [DATA_W-1:0] dbus_q, dbus_d;
  logic              cout_q, cout_d;
  logic [AW-1:0]     wb_dest_q, wb_dest_d;

  logic [DATA_W-1:0] alu_res;
  logic              alu_cout;
  logic [DATA_W-1:0] opa, opb;

  regalu_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a_i      (abus_q),
    .b_i      (bbus_q),
    .op_i     (ex_op_q),
    .cin_i    (ex_cin_q),
    .result_o (alu_res),
    .cout_o   (alu_cout)
  );

  // Operand select: r0 is zero, then youngest in-flight producer, then register file.
  always_comb begin
    opa = rf_q[asel];
    opb = rf_q[bsel];
`ifdef REGALU_BYPASS_EN
    // WB first so the EX match (younger op) overrides it.
    if (d_valid_q && (wb_dest_q == asel)) opa = dbus_q;
    if (d_valid_q && (wb_dest_q == bsel)) opb = dbus_q;
    if (ex_valid_q && (ex_dest_q == asel)) opa = alu_res;
    if (ex_valid_q && (ex_dest_q == bsel)) opb = alu_res;
`endif
    if (asel == '0) opa = '0;
    if (bsel == '0) opb = '0;
    if (imm_sel)    opb = imm;
  end

  // Read stage -> execute stage registers; operands and control hold when idle.
  always_comb begin
    ex_valid_d = in_valid;
    abus_d     = abus_q;
    bbus_d     = bbus_q;
    ex_dest_d  = ex_dest_q;
    ex_op_d    = ex_op_q;
    ex_cin_d   = ex_cin_q;
    if (in_valid) begin
      abus_d    = opa;
      bbus_d    = opb;
      ex_dest_d = dsel;
      ex_op_d   = S;
      ex_cin_d  = Cin;
    end
  end

  // Execute stage -> writeback stage registers; result holds when no op executes.
  always_comb begin
    d_valid_d = ex_valid_q;
    dbus_d    = dbus_q;
    cout_d    = cout_q;
    wb_dest_d = wb_dest_q;
    if (ex_valid_q) begin
      dbus_d    = alu_res;
      cout_d    = alu_cout;
      wb_dest_d = ex_dest_q;
    end
  end

  // Writeback into the register file; writes to r0 are dropped.
  always_comb begin
    rf_d = rf_q;
    if (d_valid_q && (wb_dest_q != '0)) rf_d[wb_dest_q] = dbus_q;
  end

  // Pipeline state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      abus_q     <= '0;
      bbus_q     <= '0;
      ex_dest_q  <= '0;
      ex_op_q    <= '0;
      ex_cin_q   <= 1'b0;
      d_valid_q  <= 1'b0;
      dbus_q     <= '0;
      cout_q     <= 1'b0;
      wb_dest_q  <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      abus_q     <= abus_d;
      bbus_q     <= bbus_d;
      ex_dest_q  <= ex_dest_d;
      ex_op_q    <= ex_op_d;
      ex_cin_q   <= ex_cin_d;
      d_valid_q  <= d_valid_d;
      dbus_q     <= dbus_d;
      cout_q     <= cout_d;
      wb_dest_q  <= wb_dest_d;
    end
  end

  // Register file storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else begin
      rf_q <= rf_d;
    end
  end

  assign abus    = abus_q;
  assign bbus    = bbus_q;
  assign dbus    = dbus_q;
  assign cout    = cout_q;
  assign d_valid = d_valid_q;

endmodule

// File: tb/tb_regalu_pipe.sv
// Self-checking bench for regalu_pipe: directed vector table, a reset
// sequence during operation, and randomized ops against a reference model
// that treats the register file as a history of committed writes.
module tb_regalu_pipe;
  import regalu_pkg::*;

  localparam int DW = 32;
  localparam int NR = 32;
`ifdef REGALU_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [4:0]    asel = '0, bsel = '0, dsel = '0;
  logic [2:0]    s_op = '0;
  logic          cin = 1'b0, imm_sel = 1'b0;
  logic [DW-1:0] imm = '0;
  logic [DW-1:0] abus, bbus, dbus;
  logic          cout, d_valid;

  regalu_pipe #(
    .DATA_W (DW),
    .NREGS  (NR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .asel     (asel),
    .bsel     (bsel),
    .dsel     (dsel),
    .S        (s_op),
    .Cin      (cin),
    .imm_sel  (imm_sel),
    .imm      (imm),
    .abus     (abus),
    .bbus     (bbus),
    .dbus     (dbus),
    .cout     (cout),
    .d_valid  (d_valid)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int failures = 0;

  // Reference model: every issued op is a write event; a read at issue edge c
  // sees the youngest write issued before c (forwarding) or only writes that
  // have already landed in the register file (issued at or before c-3).
  typedef struct { int e; int dest; logic [DW-1:0] val; } wr_t;
  wr_t hist[$];

  logic [DW-1:0] e_a = '0, e_b = '0, e_d = '0;
  logic          e_c = 1'b0, e_dv = 1'b0;
  logic          p_v = 1'b0, p_c = 1'b0;
  logic [DW-1:0] p_d = '0;

  function automatic logic [DW-1:0] mread(int s, int c);
    if (s == 0) return '0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i].dest == s && (Byp ? (hist[i].e < c) : (hist[i].e <= c - 3)))
        return hist[i].val;
    end
    return '0;
  endfunction

  // Returns {carry, result}.
  function automatic logic [DW:0] ref_alu(logic [2:0] op, logic [DW-1:0] a, logic [DW-1:0] b,
                                          logic ci);
    longint t;
    case (op)
      OP_XOR:  return {1'b0, a ^ b};
      OP_XNOR: return {1'b0, ~(a ^ b)};
      OP_OR:   return {1'b0, a | b};
      OP_NOR:  return {1'b0, ~(a | b)};
      OP_AND:  return {1'b0, a & b};
      OP_NAND: return {1'b0, ~(a & b)};
      OP_ADD:  begin t = longint'(a) + longint'(b) + longint'(ci); return t[DW:0]; end
      default: begin
        t = longint'(a) + (longint'(1) << DW) - 1 - longint'(b) + longint'(ci);
        return t[DW:0];
      end
    endcase
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    p_v = 1'b0; p_d = '0; p_c = 1'b0;
    e_a = '0; e_b = '0; e_d = '0; e_c = 1'b0; e_dv = 1'b0;
  endtask

  // Apply one issue slot, advance one edge, compare all outputs with the model.
  task automatic step(input logic iv, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic [2:0] op, input logic ci,
                      input logic isel, input logic [DW-1:0] im);
    int c;
    logic [DW:0]   r;
    logic [DW-1:0] oa, ob;
    in_valid = iv; asel = a; bsel = b; dsel = d; s_op = op; cin = ci;
    imm_sel = isel; imm = im;
    c = edge_cnt + 1;
    e_dv = p_v;
    if (p_v) begin e_d = p_d; e_c = p_c; end
    if (iv) begin
      oa = mread(int'(a), c);
      ob = isel ? im : mread(int'(b), c);
      r  = ref_alu(op, oa, ob, ci);
      e_a = oa; e_b = ob;
      p_v = 1'b1; p_d = r[DW-1:0]; p_c = r[DW];
      if (d != 0) hist.push_back('{c, int'(d), r[DW-1:0]});
    end else begin
      p_v = 1'b0;
    end
    @(posedge clk); #1;
    chk("abus", abus, e_a);
    chk("bbus", bbus, e_b);
    chk("dbus", dbus, e_d);
    chk("cout", {31'b0, cout}, {31'b0, e_c});
    chk("d_valid", {31'b0, d_valid}, {31'b0, e_dv});
  endtask

  typedef struct {
    logic iv; logic [4:0] a, b, d; logic [2:0] op; logic ci, isel; logic [DW-1:0] im;
    logic ca; logic [DW-1:0] ea;
    logic cd; logic [DW-1:0] ed; logic ec, edv;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic iv, logic [4:0] a, logic [4:0] b, logic [4:0] d,
                              logic [2:0] op, logic ci, logic isel, logic [DW-1:0] im,
                              logic ca, logic [DW-1:0] ea,
                              logic cd, logic [DW-1:0] ed, logic ec, logic edv);
    vec_t v;
    v.iv = iv; v.a = a; v.b = b; v.d = d; v.op = op; v.ci = ci; v.isel = isel; v.im = im;
    v.ca = ca; v.ea = ea; v.cd = cd; v.ed = ed; v.ec = ec; v.edv = edv;
    return v;
  endfunction

  function automatic vec_t idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic vec_t idle_d(logic [DW-1:0] ed, logic ec, logic edv);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ed, ec, edv);
  endfunction

  initial begin
    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_abus", abus, '0);
    chk("rst_bbus", bbus, '0);
    chk("rst_dbus", dbus, '0);
    chk("rst_cout", {31'b0, cout}, '0);
    chk("rst_dvalid", {31'b0, d_valid}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Idle then read of unwritten registers
    repeat (3) vecs.push_back(idle());
    vecs.push_back(mk(1, 7, 9, 0, OP_XOR, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(idle_d(0, 0, 1));
    vecs.push_back(idle_d(0, 0, 0));
    // Back-to-back dependency chain
    vecs.push_back(mk(1, 0, 0, 1, OP_ADD, 0, 1, 5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 2, OP_ADD, 0, 0, 0, 0, 0, 1, 5, 0, 1));
    vecs.push_back(mk(1, 1, 2, 3, OP_XOR, 0, 0, 0, 0, 0, 1, Byp ? 32'hA : 32'h0, 0, 1));
    vecs.push_back(idle_d(Byp ? 32'hF : 32'h0, 0, 1));
    vecs.push_back(idle_d(Byp ? 32'hF : 32'h0, 0, 0));
    repeat (2) vecs.push_back(idle());
    vecs.push_back(mk(1, 1, 0, 0, OP_XOR, 0, 0, 0, 1, 5, 0, 0, 0, 0));
    vecs.push_back(mk(1, 2, 0, 0, OP_XOR, 0, 0, 0, 1, Byp ? 32'd10 : 32'd0, 1, 5, 0, 1));
    vecs.push_back(mk(1, 3, 0, 0, OP_XOR, 0, 0, 0, 1, Byp ? 32'd15 : 32'd0,
                      1, Byp ? 32'd10 : 32'd0, 0, 1));
    vecs.push_back(idle_d(Byp ? 32'd15 : 32'd0, 0, 1));
    // Dependency separated by two idle slots works in both builds
    vecs.push_back(mk(1, 1, 1, 2, OP_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(idle_d(32'hA, 0, 1));
    vecs.push_back(idle());
    vecs.push_back(mk(1, 2, 0, 9, OP_ADD, 0, 0, 0, 1, 32'hA, 0, 0, 0, 0));
    vecs.push_back(idle());
    // SUB with staged operands
    vecs.push_back(mk(1, 0, 0, 4, OP_ADD, 0, 1, 3, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 5, OP_ADD, 0, 1, 5, 0, 0, 0, 0, 0, 0));
    repeat (2) vecs.push_back(idle());
    vecs.push_back(mk(1, 4, 5, 6, OP_SUB, 1, 0, 0, 1, 3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 4, 7, OP_SUB, 1, 0, 0, 1, 5, 1, 32'hFFFF_FFFE, 0, 1));
    vecs.push_back(idle_d(32'h2, 1, 1));
    vecs.push_back(idle());
    // Writes to r0 are dropped but d_valid still pulses
    vecs.push_back(mk(1, 0, 0, 0, OP_ADD, 0, 1, 32'h1234, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, OP_XOR, 0, 0, 0, 1, 0, 1, 32'h1234, 0, 1));
    vecs.push_back(idle_d(0, 0, 1));
    repeat (3) vecs.push_back(idle());
    vecs.push_back(mk(1, 0, 5, 0, OP_XOR, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vecs.push_back(idle());

    foreach (vecs[i]) begin
      step(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].op, vecs[i].ci,
           vecs[i].isel, vecs[i].im);
      if (vecs[i].ca) chk($sformatf("v%0d_abus", i), abus, vecs[i].ea);
      if (vecs[i].cd) begin
        chk($sformatf("v%0d_dbus", i), dbus, vecs[i].ed);
        chk($sformatf("v%0d_cout", i), {31'b0, cout}, {31'b0, vecs[i].ec});
        chk($sformatf("v%0d_dvalid", i), {31'b0, d_valid}, {31'b0, vecs[i].edv});
      end
    end

    // Asynchronous reset while an op is in flight
    step(1, 0, 0, 8, OP_ADD, 0, 1, 32'hAA);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_abus", abus, '0);
    chk("mid_rst_bbus", bbus, '0);
    chk("mid_rst_dbus", dbus, '0);
    chk("mid_rst_cout", {31'b0, cout}, '0);
    chk("mid_rst_dvalid", {31'b0, d_valid}, '0);
    @(posedge clk); #1;
    chk("in_rst_dvalid", {31'b0, d_valid}, '0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_dvalid", {31'b0, d_valid}, '0);
    step(1, 8, 0, 0, OP_XOR, 0, 0, 0);
    chk("post_rst_r8", abus, '0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_dbus", dbus, '0);

    // Randomized traffic, mostly on a few registers to stress hazards
    repeat (400) begin
      logic [4:0] ra, rb, rd;
      ra = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rb = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      rd = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
      step(($urandom_range(0, 3) != 0), ra, rb, rd, 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom);
    end
    repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
